// File: rtl/maxnet_data_loader.sv
// maxnet_data_loader: streams activation words from a valid/ready source into
// the Maxnet data memory at addresses 0..DEPTH-1. Each accepted word produces
// one registered write. done is raised once a full or short load completes.
module maxnet_data_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [ADDR_WIDTH:0]   r_count, w_count_nxt;
  // Low only for the first edge after reset release, so a start pulse that
  // overlaps the release cannot launch a load.
  logic                  r_armed;
  logic                  r_wr_en_p1, w_wr_en_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_addr_p1, w_wr_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wr_data_p1, w_wr_data_nxt;
  logic                  w_hs;
  logic                  w_final_word;

  assign in_ready     = (r_state == S_LOAD);
  assign done         = (r_state == S_DONE);
  assign w_hs         = in_ready & in_valid;
  assign w_final_word = (r_addr == LAST_ADDR) | in_last;

  assign wr_en   = r_wr_en_p1;
  assign wr_addr = r_wr_addr_p1;
  assign wr_data = r_wr_data_p1;
  assign count   = r_count;

  // State, address/count and the registered write port; all cleared on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_count      <= '0;
      r_armed      <= 1'b0;
      r_wr_en_p1   <= 1'b0;
      r_wr_addr_p1 <= '0;
      r_wr_data_p1 <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_count      <= w_count_nxt;
      r_armed      <= 1'b1;
      // ---- write stage (p1): one cycle after the accepting edge ----
      r_wr_en_p1   <= w_wr_en_nxt;
      r_wr_addr_p1 <= w_wr_addr_nxt;
      r_wr_data_p1 <= w_wr_data_nxt;
    end
  end

  // Next-state and write-port decode; wr_addr/wr_data hold when no word is accepted.
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_count_nxt   = r_count;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr_p1;
    w_wr_data_nxt = r_wr_data_p1;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start && r_armed) begin
          w_state_nxt = S_LOAD;
          w_addr_nxt  = '0;
          w_count_nxt = '0;
        end
      end
      S_LOAD: begin
        // start is deliberately not examined here: a load runs to completion.
        if (w_hs) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = r_addr;
          w_wr_data_nxt = in_data;
          w_addr_nxt    = r_addr + ADDR_WIDTH'(1);
          w_count_nxt   = r_count + (ADDR_WIDTH + 1)'(1);
          if (w_final_word) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_maxnet_data_loader.sv
// Randomized scoreboard bench for maxnet_data_loader. A transaction-level model
// predicts which words are accepted and where they land; a monitor checks every
// write pulse against the queue of predicted writes.
module tb_maxnet_data_loader;

  localparam int DW = 32;
  localparam int D  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   count;
  logic          done;

  maxnet_data_loader #(.DATA_WIDTH(DW), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .count(count), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t exp_q[$];

  // Data memory fed by the DUT write port, and the memory the model predicts.
  logic [DW-1:0] mem [D];
  logic [DW-1:0] exp_mem [D];

  // Transaction-level model state.
  bit m_loading = 0;
  bit m_done    = 0;
  bit m_armed   = 0;
  int m_idx     = 0;

  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse must match the oldest predicted write.
  always @(negedge clk) begin
    if (rst && wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr_en", 64'(wr_en), 64'(0));
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e.a));
        chk("wr_data", 64'(wr_data), 64'(e.d));
      end
    end
  end

  // One clock: check status against the model, apply inputs, advance the model
  // over the coming edge. Entered and left at negedge+1.
  task automatic drive(input bit v, input bit l, input logic [DW-1:0] d, input bit st);
    chk("in_ready", 64'(in_ready), 64'(m_loading));
    chk("done", 64'(done), 64'(m_done));
    chk("count", 64'(count), 64'(m_idx));
    start = st; in_valid = v; in_last = l; in_data = d;
    if (m_loading) begin
      if (v) begin
        exp_q.push_back('{a: AW'(m_idx), d: d});
        exp_mem[m_idx] = d;
        m_idx++;
        if (m_idx == D || l) begin
          m_loading = 0;
          m_done    = 1;
        end
      end
    end else if (st && m_armed) begin
      m_loading = 1;
      m_done    = 0;
      m_idx     = 0;
    end
    m_armed = 1;
    @(negedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom, 1'b0);
  endtask

  task automatic check_mem();
    for (int i = 0; i < D; i++) chk($sformatf("mem[%0d]", i), 64'(mem[i]), 64'(exp_mem[i]));
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  // Assert reset with start/valid active, check values, release with start held.
  task automatic do_reset();
    rst = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = $urandom; #1;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    exp_q.delete();
    m_loading = 0; m_done = 0; m_idx = 0; m_armed = 0;
    @(negedge clk); #1;
    chk("rst_hold_in_ready", 64'(in_ready), 64'(0));
    chk("rst_hold_wr_en", 64'(wr_en), 64'(0));
    rst = 1'b1;
    // First edge after release: start still high and must be ignored.
    drive(1'b1, 1'b0, $urandom, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  // Start a load and feed the words; gap<0 picks 0..2 idle cycles at random.
  task automatic load(input logic [DW-1:0] w[$], input bit use_last, input int gap);
    drive(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < w.size(); i++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int k = 0; k < g; k++) drive(1'b0, bit'($urandom_range(0, 1)), $urandom, 1'b0);
      drive(1'b1, use_last && (i == w.size() - 1), w[i], 1'b0);
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b1, $urandom, 1'b0);
    check_mem();
  endtask

  initial begin
    logic [DW-1:0] w[$];
    rst = 1'b0;
    @(negedge clk); #1;
    do_reset();
    idle_cycles(2);

    // Full back-to-back load.
    w = '{32'h11, 32'h22, 32'h33, 32'h44};
    load(w, 1'b0, 0);
    chk("full_count", 64'(count), 64'(4));
    chk("full_done", 64'(done), 64'(1));

    // Same words with two idle cycles between each.
    load(w, 1'b0, 2);

    // Short load terminated by in_last.
    w = '{32'hA, 32'hB};
    load(w, 1'b1, 0);
    chk("short_count", 64'(count), 64'(2));

    // start mid-load is ignored; restart after done begins at address 0.
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b1, 1'b0, 32'h1111_0000, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b1, 1'b0, 32'h2222_0000, 1'b1);
    drive(1'b1, 1'b0, 32'h3333_0000, 1'b0);
    drive(1'b1, 1'b0, 32'h4444_0000, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    check_mem();
    w = '{32'h5555_0000};
    load(w, 1'b1, 0);

    // Reset after two accepted words.
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b1, 1'b0, 32'hCAFE_0001, 1'b0);
    drive(1'b1, 1'b0, 32'hCAFE_0002, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    do_reset();
    check_mem();
    w = '{$urandom, $urandom, $urandom, $urandom};
    load(w, 1'b0, 0);

    // Randomized loads of random length, gaps and idle noise.
    for (int t = 0; t < 25; t++) begin
      int n;
      bit ul;
      n = int'($urandom_range(1, D));
      ul = (n < D) ? 1'b1 : bit'($urandom_range(0, 1));
      w.delete();
      for (int i = 0; i < n; i++) w.push_back($urandom);
      idle_cycles(int'($urandom_range(0, 2)));
      load(w, ul, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
